// File: rtl/lcd_bus_scheduler_if.sv
// Requester-side handshake bundle for lcd_bus_scheduler.
// Two requesters, each with VALID/RS/DATA toward the scheduler and READY back.
//   master : requester side (drives VALID/RS/DATA, observes READY)
//   slave  : scheduler side (observes VALID/RS/DATA, drives READY)
interface lcd_bus_scheduler_if;
  logic       REQ0_VALID;
  logic       REQ0_RS;
  logic [7:0] REQ0_DATA;
  logic       REQ0_READY;
  logic       REQ1_VALID;
  logic       REQ1_RS;
  logic [7:0] REQ1_DATA;
  logic       REQ1_READY;

  modport master (
    output REQ0_VALID, REQ0_RS, REQ0_DATA,
    output REQ1_VALID, REQ1_RS, REQ1_DATA,
    input  REQ0_READY, REQ1_READY
  );

  modport slave (
    input  REQ0_VALID, REQ0_RS, REQ0_DATA,
    input  REQ1_VALID, REQ1_RS, REQ1_DATA,
    output REQ0_READY, REQ1_READY
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Shared-access controller for the 8-bit character LCD bus.
// Two requesters submit command/character writes over valid/ready; the block
// arbitrates round-robin and drives DB/RS/RW/E with setup, enable-pulse and
// settle timing, after an initial power-on wait.
// Ports:
//   CLOCK_50MHZ         system clock
//   BUTTON_SOUTH        synchronous active-high reset
//   req_bus             requester handshakes (slave modport)
//   LCD_DATA_BIT[7:0]   LCD DB
//   LCD_ENABLE          LCD E
//   LCD_REGISTER_SELECT LCD RS
//   LCD_READ_WRITE      LCD R/W, always 0
//   BUSY                high whenever not idle
//   LAST_GRANT          id of the most recently accepted requester
module lcd_bus_scheduler #(
  parameter int unsigned POWERON_WAIT = 750000,
  parameter int unsigned SETUP_WAIT   = 2,
  parameter int unsigned PULSE_WAIT   = 12,
  parameter int unsigned SHORT_WAIT   = 2000,
  parameter int unsigned LONG_WAIT    = 82000
) (
  input  logic                        CLOCK_50MHZ,
  input  logic                        BUTTON_SOUTH,
  lcd_bus_scheduler_if.slave          req_bus,
  output logic [7:0]                  LCD_DATA_BIT,
  output logic                        LCD_ENABLE,
  output logic                        LCD_REGISTER_SELECT,
  output logic                        LCD_READ_WRITE,
  output logic                        BUSY,
  output logic                        LAST_GRANT
);

  typedef enum logic [2:0] {
    ST_POWERON,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE
  } state_t;

  localparam logic [31:0] POWERON_LAST = 32'(POWERON_WAIT - 1);
  localparam logic [31:0] SETUP_LAST   = 32'(SETUP_WAIT - 1);
  localparam logic [31:0] PULSE_LAST   = 32'(PULSE_WAIT - 1);
  localparam logic [31:0] SHORT_LAST   = 32'(SHORT_WAIT - 1);
  localparam logic [31:0] LONG_LAST    = 32'(LONG_WAIT - 1);

  state_t      state, state_next;
  logic [31:0] cnt;
  logic [7:0]  db_q;
  logic        rs_q;
  logic        e_q;
  logic        last_q;
  logic        ptr_q;

  logic        winner;
  logic        any_valid;
  logic        handshake;
  logic        settle_long;
  logic [31:0] settle_last;

  // Arbitration: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    winner = ptr_q;
    if (req_bus.REQ0_VALID && !req_bus.REQ1_VALID) winner = 1'b0;
    if (req_bus.REQ1_VALID && !req_bus.REQ0_VALID) winner = 1'b1;
  end

  assign any_valid = req_bus.REQ0_VALID | req_bus.REQ1_VALID;
  assign handshake = (state == ST_IDLE) && any_valid;

  assign req_bus.REQ0_READY = (state == ST_IDLE) && req_bus.REQ0_VALID && !winner;
  assign req_bus.REQ1_READY = (state == ST_IDLE) && req_bus.REQ1_VALID &&  winner;

  // Clear display (0x01) and return home (0x02/0x03) need the long settle.
  assign settle_long = !rs_q && (db_q[7:2] == 6'd0) && (db_q[1:0] != 2'd0);
  assign settle_last = settle_long ? LONG_LAST : SHORT_LAST;

  always_comb begin
    state_next = state;
    case (state)
      ST_POWERON: if (cnt == POWERON_LAST) state_next = ST_IDLE;
      ST_IDLE:    if (handshake)           state_next = ST_SETUP;
      ST_SETUP:   if (cnt == SETUP_LAST)   state_next = ST_PULSE;
      ST_PULSE:   if (cnt == PULSE_LAST)   state_next = ST_SETTLE;
      ST_SETTLE:  if (cnt == settle_last)  state_next = ST_IDLE;
      default:                             state_next = ST_POWERON;
    endcase
  end

  always_ff @(posedge CLOCK_50MHZ) begin
    if (BUTTON_SOUTH) begin
      state  <= ST_POWERON;
      cnt    <= '0;
      db_q   <= '0;
      rs_q   <= 1'b0;
      e_q    <= 1'b0;
      last_q <= 1'b0;
      ptr_q  <= 1'b0;
    end else begin
      state <= state_next;
      // Counter restarts on every state entry; it is held at zero while idle.
      if (state_next != state || state == ST_IDLE) cnt <= '0;
      else                                         cnt <= cnt + 32'd1;
      // E is registered from the next state so it tracks PULSE exactly and
      // never toggles in the cycle DB/RS are loaded.
      e_q <= (state_next == ST_PULSE);
      if (handshake) begin
        db_q   <= winner ? req_bus.REQ1_DATA : req_bus.REQ0_DATA;
        rs_q   <= winner ? req_bus.REQ1_RS   : req_bus.REQ0_RS;
        last_q <= winner;
        ptr_q  <= ~winner;
      end
    end
  end

  assign LCD_DATA_BIT        = db_q;
  assign LCD_REGISTER_SELECT = rs_q;
  assign LCD_ENABLE          = e_q;
  assign LCD_READ_WRITE      = 1'b0;
  assign BUSY                = (state != ST_IDLE);
  assign LAST_GRANT          = last_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
module tb_lcd_bus_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] lcd_db;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       busy;
  logic       last_grant;

  int checks = 0;
  int errors = 0;

  lcd_bus_scheduler_if bus ();

  lcd_bus_scheduler #(
    .POWERON_WAIT (10),
    .SETUP_WAIT   (2),
    .PULSE_WAIT   (3),
    .SHORT_WAIT   (5),
    .LONG_WAIT    (20)
  ) dut (
    .CLOCK_50MHZ         (clk),
    .BUTTON_SOUTH        (rst),
    .req_bus             (bus.slave),
    .LCD_DATA_BIT        (lcd_db),
    .LCD_ENABLE          (lcd_e),
    .LCD_REGISTER_SELECT (lcd_rs),
    .LCD_READ_WRITE      (lcd_rw),
    .BUSY                (busy),
    .LAST_GRANT          (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_idle;   // cycles after the handshake edge until READY again
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one write from requester `id` starting in an idle cycle; returns
  // READY as seen before the edge, DB/RS at T+1, an E-per-cycle mask and the
  // first cycle (relative to T) in which the block is idle again.
  task automatic xfer(input bit id, input bit rs, input logic [7:0] d,
                      output bit rdy, output logic [7:0] db1, output bit rs1,
                      output logic [31:0] emask, output int kidle);
    if (id) begin
      bus.REQ1_VALID = 1'b1; bus.REQ1_RS = rs; bus.REQ1_DATA = d;
    end else begin
      bus.REQ0_VALID = 1'b1; bus.REQ0_RS = rs; bus.REQ0_DATA = d;
    end
    #1;
    rdy = id ? bus.REQ1_READY : bus.REQ0_READY;
    step();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    db1 = lcd_db;
    rs1 = lcd_rs;
    emask = '0;
    kidle = 0;
    for (int k = 1; k < 31; k++) begin
      if (!busy) begin
        kidle = k;
        break;
      end
      if (lcd_e) emask[k] = 1'b1;
      step();
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) chk(nm, 32'(busy), 32'd0);
  endtask

  bit          rdy, rs1;
  logic [7:0]  db1;
  logic [31:0] emask;
  int          kidle;
  int          n;

  initial begin
    vecs[0] = '{rs: 1'b1, data: 8'h64, exp_idle: 11};
    vecs[1] = '{rs: 1'b0, data: 8'h01, exp_idle: 26};
    vecs[2] = '{rs: 1'b0, data: 8'h02, exp_idle: 26};
    vecs[3] = '{rs: 1'b0, data: 8'h38, exp_idle: 11};
    vecs[4] = '{rs: 1'b1, data: 8'h01, exp_idle: 11};
    vecs[5] = '{rs: 1'b0, data: 8'h03, exp_idle: 26};
    vecs[6] = '{rs: 1'b0, data: 8'h04, exp_idle: 11};
    vecs[7] = '{rs: 1'b0, data: 8'h00, exp_idle: 11};

    bus.REQ0_VALID = 1'b0; bus.REQ0_RS = 1'b0; bus.REQ0_DATA = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_RS = 1'b0; bus.REQ1_DATA = '0;

    // ---------------- power-on ----------------
    rst = 1'b1;
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b0; bus.REQ0_DATA = 8'h38;
    step(); step(); step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready0", 32'(bus.REQ0_READY), 32'd0);
    chk("rst_lcd", {lcd_db, 5'd0, lcd_e, lcd_rs, lcd_rw, 7'd0, last_grant}, '0);
    rst = 1'b0;
    #1;
    n = 0;
    while (!bus.REQ0_READY && n < 50) begin
      if (!busy || lcd_e || lcd_rs || lcd_rw || lcd_db != 8'h00)
        chk("poweron_hold", {lcd_db, 4'd0, busy, lcd_e, lcd_rs, lcd_rw}, 32'h0000_0008);
      step();
      n++;
    end
    chk("poweron_cycles", 32'(n), 32'd10);
    chk("poweron_busy_low", 32'(busy), 32'd0);
    xfer(1'b0, 1'b0, 8'h38, rdy, db1, rs1, emask, kidle);
    chk("poweron_grant", 32'(rdy), 32'd1);
    chk("poweron_db", 32'(db1), 32'h38);

    // ---------------- table-driven single writes ----------------
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, vecs[i].rs, vecs[i].data, rdy, db1, rs1, emask, kidle);
      chk($sformatf("v%0d_ready", i), 32'(rdy), 32'd1);
      chk($sformatf("v%0d_db", i), 32'(db1), 32'(vecs[i].data));
      chk($sformatf("v%0d_rs", i), 32'(rs1), 32'(vecs[i].rs));
      chk($sformatf("v%0d_e_window", i), emask, 32'h0000_0038);
      chk($sformatf("v%0d_idle_at", i), 32'(kidle), 32'(vecs[i].exp_idle));
      chk($sformatf("v%0d_hold", i), {23'd0, lcd_rs, lcd_db}, {23'd0, vecs[i].rs, vecs[i].data});
      chk($sformatf("v%0d_grant", i), 32'(last_grant), 32'd0);
    end

    // ---------------- REQ1 alone, 3 back-to-back writes ----------------
    begin
      logic [7:0]  bytes [3];
      int          g;
      int unsigned last_cyc;
      bytes[0] = 8'h48; bytes[1] = 8'h69; bytes[2] = 8'h21;
      g = 0;
      last_cyc = 0;
      bus.REQ1_VALID = 1'b1; bus.REQ1_RS = 1'b1; bus.REQ1_DATA = bytes[0];
      for (int c = 0; c < 60 && g < 3; c++) begin
        #1;
        if (bus.REQ0_READY) chk("r1_ready0", 32'(bus.REQ0_READY), 32'd0);
        if (bus.REQ1_READY) begin
          if (g > 0) chk($sformatf("r1_period%0d", g), 32'(cyc - last_cyc), 32'd11);
          last_cyc = cyc;
          step();
          chk($sformatf("r1_db%0d", g), 32'(lcd_db), 32'(bytes[g]));
          chk($sformatf("r1_grant%0d", g), 32'(last_grant), 32'd1);
          g++;
          if (g < 3) bus.REQ1_DATA = bytes[g];
          else       bus.REQ1_VALID = 1'b0;
        end else begin
          step();
        end
      end
      bus.REQ1_VALID = 1'b0;
      chk("r1_count", 32'(g), 32'd3);
      wait_idle("r1_idle_timeout");
    end

    // ---------------- contention ----------------
    begin
      int g;
      g = 0;
      bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h41;
      bus.REQ1_VALID = 1'b1; bus.REQ1_RS = 1'b1; bus.REQ1_DATA = 8'h42;
      for (int c = 0; c < 80 && g < 4; c++) begin
        #1;
        if (bus.REQ0_READY && bus.REQ1_READY) chk("cont_both_ready", 32'd1, 32'd0);
        if (bus.REQ0_READY || bus.REQ1_READY) begin
          chk($sformatf("cont_id%0d", g), 32'(bus.REQ1_READY), 32'(g % 2));
          step();
          chk($sformatf("cont_last%0d", g), 32'(last_grant), 32'(g % 2));
          chk($sformatf("cont_db%0d", g), 32'(lcd_db), (g % 2) ? 32'h42 : 32'h41);
          g++;
        end else begin
          step();
        end
      end
      bus.REQ0_VALID = 1'b0;
      bus.REQ1_VALID = 1'b0;
      chk("cont_count", 32'(g), 32'd4);
      wait_idle("cont_idle_timeout");
    end

    // ---------------- reset in the middle of PULSE ----------------
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h55;
    #1;
    chk("mid_ready0", 32'(bus.REQ0_READY), 32'd1);
    step();                       // T+1
    bus.REQ0_VALID = 1'b0;
    step(); step();               // T+3
    chk("mid_e_before", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_e_after", 32'(lcd_e), 32'd0);
    chk("mid_db_after", 32'(lcd_db), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd1);
    rst = 1'b0;
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h30;
    bus.REQ1_VALID = 1'b1; bus.REQ1_RS = 1'b1; bus.REQ1_DATA = 8'h31;
    #1;
    n = 0;
    while (!bus.REQ0_READY && !bus.REQ1_READY && n < 50) begin
      step();
      n++;
    end
    chk("mid_poweron_cycles", 32'(n), 32'd10);
    chk("mid_first_ready0", 32'(bus.REQ0_READY), 32'd1);
    chk("mid_first_ready1", 32'(bus.REQ1_READY), 32'd0);
    step();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    chk("mid_last_grant", 32'(last_grant), 32'd0);
    chk("mid_db", 32'(lcd_db), 32'h30);
    wait_idle("mid_idle_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Shared-access controller for the 8-bit character LCD bus on the Spartan 3AN board. Two independent requesters submit command or character writes over valid/ready handshakes; the block arbitrates round-robin, drives LCD data/RS/RW/E with the required setup, enable-pulse and settle timing, and enforces the power-on delay before the first write. Higher-level sequencers (init sequence, message writer, debug writer) sit on its request ports instead of driving the LCD pins directly.

## Interface
- `POWERON_WAIT`, default 750000: cycles held idle after reset before the first grant.
- `SETUP_WAIT`, default 2: cycles data/RS are stable before E rises; must be ≥1.
- `PULSE_WAIT`, default 12: cycles E is held high; must be ≥1.
- `SHORT_WAIT`, default 2000: settle cycles after a normal write; must be ≥1.
- `LONG_WAIT`, default 82000: settle cycles after clear or return-home; must be ≥1.
- `CLOCK_50MHZ  in  1`  system clock; the only clock.
- `BUTTON_SOUTH  in  1`  reset, synchronous, active-high.
- `REQ0_VALID  in  1`  requester 0 has a write pending.
- `REQ0_RS  in  1`  requester 0 register select (0 command, 1 data).
- `REQ0_DATA  in  8`  requester 0 byte.
- `REQ0_READY  out  1`  requester 0 write accepted this cycle.
- `REQ1_VALID`, `REQ1_RS`, `REQ1_DATA`, `REQ1_READY`: same as requester 0.
- `LCD_DATA_BIT  out  8`  LCD DB[7:0].
- `LCD_ENABLE  out  1`  LCD E.
- `LCD_REGISTER_SELECT  out  1`  LCD RS.
- `LCD_READ_WRITE  out  1`  LCD R/W; constant 0 (write only).
- `BUSY  out  1`  high whenever state ≠ IDLE.
- `LAST_GRANT  out  1`  ID of the most recently accepted requester.

## Operation
- Reset: when `BUTTON_SOUTH` is high at a clock edge, the block sets state=POWERON and counter=0. It clears `LCD_DATA_BIT`, `LCD_ENABLE`, `LCD_REGISTER_SELECT`, `LCD_READ_WRITE` and `LAST_GRANT` to 0, and sets the priority pointer to 0. Both READY outputs are 0 and BUSY is 1. Reset overrides any handshake in the same cycle.
- States: POWERON → IDLE → SETUP → PULSE → SETTLE → IDLE.
- Dwell rule: every timed state lasts exactly N cycles, counting 0..N-1. The counter is 32 bits and clears on each state entry.
- POWERON: dwells `POWERON_WAIT` cycles, then enters IDLE.
- IDLE (arbitration):
  - Winner is combinational from the valid inputs.
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by the priority pointer wins.
  - READY is high only for the winner, and only while in IDLE.
- Handshake: VALID & READY at a clock edge.
  - The block registers the winner's RS into `LCD_REGISTER_SELECT` and its DATA into `LCD_DATA_BIT`, and sets `LAST_GRANT` to the winner.
  - The pointer moves to the other requester.
  - State goes to SETUP.
- Requester rules: VALID and the payload must hold until READY; the block samples only on the handshake.
- SETUP: E=0 for `SETUP_WAIT` cycles, then PULSE.
- PULSE: E=1 for `PULSE_WAIT` cycles, then SETTLE.
- SETTLE: E=0. Dwell is `LONG_WAIT` if RS=0 and DATA[7:2]=0 and DATA[1:0]≠0 (clear or return home); otherwise `SHORT_WAIT`. Then IDLE.
- Hold: data and RS keep the last written value until the next handshake.

## Timing
- Handshake at edge T:
  - DB and RS are valid from T+1.
  - E is high for cycles T+1+S through T+S+P.
  - Next READY is possible in cycle T+1+S+P+W.
  - S, P and W are SETUP, PULSE and the selected settle wait.
- Back-to-back write period: 1+S+P+W cycles. No bubbles beyond that.
- Defaults: 1+2+12+2000 = 2015 cycles per normal write; 1+2+12+82000 = 82015 cycles per clear.
- E never changes in the same cycle as DB or RS.
- Reset mid-write: E is 0 from the cycle after reset is sampled, and the full POWERON wait repeats.

## Test plan
Parameters for all scenarios: POWERON=10, SETUP=2, PULSE=3, SHORT=5, LONG=20.
- Power-on: reset is held 3 cycles and then released with REQ0_VALID=1. BUSY=1 and READY=0 for 10 cycles; then REQ0_READY=1 and BUSY=0. All LCD outputs are 0 before the grant.
- Single data write: REQ0 RS=1, DATA=0x64, handshake at T. Required response:
  - DB=0x64 and RS=1 at T+1.
  - E=1 exactly in T+3..T+5.
  - BUSY=0 and REQ0_READY=1 at T+11.
- Clear vs. normal:
  - RS=0, 0x01 gives next READY at T+26.
  - RS=0, 0x02 gives T+26.
  - RS=0, 0x38 gives T+11.
  - RS=1, 0x01 gives T+11.
- Contention: both VALID held high continuously. Grants alternate 0,1,0,1; LAST_GRANT follows; no cycle has both READY high.
- Single requester repeat: only REQ1 valid across 3 writes. All 3 are granted to REQ1 at an 11-cycle period, and each byte appears on DB in order.
- Reset mid-pulse: BUTTON_SOUTH is asserted during PULSE.
  - E=0 and DB=0 the next cycle.
  - READY=0 for the next 10 cycles after release.
  - With both VALID, the first grant goes to REQ0.
